// File: rtl/blk_hdr_assembler.sv
// Assembles a SYNC-framed UART byte stream into the 640-bit block header for the mining engine.
// Optional trailing XOR checksum byte is enabled by defining HDR_CHKSUM_EN.
module blk_hdr_assembler #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic         system_clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_vld,
  output logic [639:0] blk_hdr,
  output logic         hdr_vld,
  output logic [7:0]   hdr_cnt,
  output logic         busy,
  output logic         err_tmo,
  output logic         err_chk
);

  localparam int HDR_BYTES = 80;
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [6:0]    LAST_IDX = 7'(HDR_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    CHK  = 2'd2,
    PUB  = 2'd3
  } state_t;

  state_t         state;
  logic [639:0]   shadow;
  logic [639:0]   shifted;
  logic [6:0]     byte_cnt;
  logic [TW-1:0]  timer;

`ifdef HDR_CHKSUM_EN
  logic [7:0]     xor_acc;

  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  assign err_chk = 1'b0;
`endif

  // The final payload byte is folded in here so publishing can happen on the same edge.
  assign shifted = {shadow[631:0], rx_data};

  // Frame FSM, shadow buffer, inter-byte timer and all registered outputs.
  always_ff @(posedge system_clk) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= {640{1'b0}};
      byte_cnt <= 7'd0;
      timer    <= {TW{1'b0}};
      blk_hdr  <= {640{1'b0}};
      hdr_vld  <= 1'b0;
      hdr_cnt  <= 8'd0;
      busy     <= 1'b0;
      err_tmo  <= 1'b0;
`ifdef HDR_CHKSUM_EN
      xor_acc  <= 8'd0;
      err_chk  <= 1'b0;
`endif
    end else begin
      hdr_vld <= 1'b0;
      err_tmo <= 1'b0;
`ifdef HDR_CHKSUM_EN
      err_chk <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rx_vld && (rx_data == SYNC_BYTE)) begin
            state    <= RECV;
            byte_cnt <= 7'd0;
            timer    <= {TW{1'b0}};
            busy     <= 1'b1;
`ifdef HDR_CHKSUM_EN
            xor_acc  <= 8'd0;
`endif
          end else begin
            busy <= 1'b0;
          end
        end

        RECV, CHK: begin
          // An arriving byte always beats an expiring timer.
          if (rx_vld) begin
            timer <= {TW{1'b0}};
            if (state == RECV) begin
              shadow   <= shifted;
              byte_cnt <= byte_cnt + 7'd1;
`ifdef HDR_CHKSUM_EN
              xor_acc  <= xor_fold(xor_acc, rx_data);
              if (byte_cnt == LAST_IDX) begin
                state <= CHK;
              end else begin
                state <= RECV;
              end
`else
              if (byte_cnt == LAST_IDX) begin
                blk_hdr <= shifted;
                hdr_vld <= 1'b1;
                hdr_cnt <= hdr_cnt + 8'd1;
                busy    <= 1'b0;
                state   <= PUB;
              end else begin
                state <= RECV;
              end
`endif
            end else begin
`ifdef HDR_CHKSUM_EN
              busy <= 1'b0;
              if (rx_data == xor_acc) begin
                blk_hdr <= shadow;
                hdr_vld <= 1'b1;
                hdr_cnt <= hdr_cnt + 8'd1;
                state   <= PUB;
              end else begin
                err_chk <= 1'b1;
                state   <= IDLE;
              end
`else
              busy  <= 1'b0;
              state <= IDLE;
`endif
            end
          end else if (timer == TMO_LAST) begin
            err_tmo <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        PUB: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blk_hdr_assembler.sv
// Directed, table-driven bench for blk_hdr_assembler (runs with a short inter-byte timeout).
module tb_blk_hdr_assembler;

  localparam int TMO = 64;

  logic         system_clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_data;
  logic         rx_vld;
  logic [639:0] blk_hdr;
  logic         hdr_vld;
  logic [7:0]   hdr_cnt;
  logic         busy;
  logic         err_tmo;
  logic         err_chk;

  always #5 system_clk = ~system_clk;

  blk_hdr_assembler #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .system_clk(system_clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .blk_hdr   (blk_hdr),
    .hdr_vld   (hdr_vld),
    .hdr_cnt   (hdr_cnt),
    .busy      (busy),
    .err_tmo   (err_tmo),
    .err_chk   (err_chk)
  );

  int n_err = 0;
  int n_checks = 0;
  int n_vld = 0;
  int n_tmo = 0;
  int n_cerr = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge system_clk) begin
    if (hdr_vld) n_vld++;
    if (err_tmo) n_tmo++;
    if (err_chk) n_cerr++;
  end

  typedef struct {
    logic       junk;
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    tick();
    rx_vld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [639:0] frame_model(input logic [7:0] base, input logic [7:0] step);
    logic [639:0] r;
    logic [7:0]   b;
    r = {640{1'b0}};
    b = base;
    for (int i = 0; i < 80; i++) begin
      r = {r[631:0], b};
      b = b + step;
    end
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    logic [7:0] x;
    b = base;
    x = 8'd0;
    send_byte(8'hA5);
    for (int i = 0; i < 80; i++) begin
      send_byte(b);
      x = x ^ b;
      b = b + step;
    end
`ifdef HDR_CHKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    rx_vld  = 1'b0;
    rx_data = 8'h00;
    idle(3);
    rst = 1'b0;
  endtask

  initial begin
    logic [639:0] saved;
    int           v0;
    int           t0;

    vecs[0] = '{junk: 1'b0, base: 8'h00, step: 8'h01, exp_first: 8'h00, exp_last: 8'h4F, exp_cnt: 8'd1};
    vecs[1] = '{junk: 1'b1, base: 8'hFF, step: 8'h00, exp_first: 8'hFF, exp_last: 8'hFF, exp_cnt: 8'd2};
    vecs[2] = '{junk: 1'b0, base: 8'h10, step: 8'h02, exp_first: 8'h10, exp_last: 8'hAE, exp_cnt: 8'd3};
    vecs[3] = '{junk: 1'b0, base: 8'hA5, step: 8'h00, exp_first: 8'hA5, exp_last: 8'hA5, exp_cnt: 8'd4};
    vecs[4] = '{junk: 1'b0, base: 8'hA5, step: 8'h00, exp_first: 8'hA5, exp_last: 8'hA5, exp_cnt: 8'd5};
    vecs[5] = '{junk: 1'b0, base: 8'h80, step: 8'h03, exp_first: 8'h80, exp_last: 8'h6D, exp_cnt: 8'd6};

    do_reset();
    check("rst_blk_hdr", blk_hdr, {640{1'b0}});
    check("rst_hdr_vld", {639'd0, hdr_vld}, 640'd0);
    check("rst_hdr_cnt", {632'd0, hdr_cnt}, 640'd0);
    check("rst_busy", {639'd0, busy}, 640'd0);
    check("rst_err_tmo", {639'd0, err_tmo}, 640'd0);
    check("rst_err_chk", {639'd0, err_chk}, 640'd0);

    // Table-driven frames: junk before SYNC, SYNC-valued payload, identical re-send.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].junk) begin
        send_byte(8'h3C);
        send_byte(8'h11);
      end
      v0 = n_vld;
      send_frame(vecs[i].base, vecs[i].step);
      check($sformatf("v%0d_hdr_vld", i), {639'd0, hdr_vld}, {639'd0, 1'b1});
      check($sformatf("v%0d_blk_hdr", i), blk_hdr, frame_model(vecs[i].base, vecs[i].step));
      check($sformatf("v%0d_first", i), {632'd0, blk_hdr[639:632]}, {632'd0, vecs[i].exp_first});
      check($sformatf("v%0d_last", i), {632'd0, blk_hdr[7:0]}, {632'd0, vecs[i].exp_last});
      check($sformatf("v%0d_hdr_cnt", i), {632'd0, hdr_cnt}, {632'd0, vecs[i].exp_cnt});
      check($sformatf("v%0d_busy", i), {639'd0, busy}, 640'd0);
      if (vecs[i].junk) check("v1_all_ones", blk_hdr, {640{1'b1}});
      tick();
      check($sformatf("v%0d_vld_drop", i), {639'd0, hdr_vld}, 640'd0);
      check($sformatf("v%0d_one_pulse", i), 640'(n_vld - v0), 640'd1);
    end

    // SYNC arriving in the publish cycle is lost; following bytes are dropped.
    send_frame(8'h20, 8'h01);
    check("pub_vld", {639'd0, hdr_vld}, {639'd0, 1'b1});
    v0 = n_vld + 1;
    send_byte(8'hA5);
    for (int i = 0; i < 80; i++) send_byte(8'h33);
    idle(2);
    check("pubdrop_no_vld", 640'(n_vld - v0), 640'd0);
    check("pubdrop_blk_hdr", blk_hdr, frame_model(8'h20, 8'h01));
    check("pubdrop_cnt", {632'd0, hdr_cnt}, 640'd7);
    check("pubdrop_busy", {639'd0, busy}, 640'd0);
    send_frame(8'h40, 8'h05);
    check("after_drop_blk_hdr", blk_hdr, frame_model(8'h40, 8'h05));
    check("after_drop_cnt", {632'd0, hdr_cnt}, 640'd8);
    tick();

    // Inter-byte timeout after 40 payload bytes.
    saved = blk_hdr;
    v0 = n_vld;
    t0 = n_tmo;
    send_byte(8'hA5);
    for (int i = 0; i < 40; i++) send_byte(8'h77);
    check("tmo_busy", {639'd0, busy}, {639'd0, 1'b1});
    idle(TMO - 1);
    check("tmo_not_early", {639'd0, err_tmo}, 640'd0);
    check("tmo_busy_late", {639'd0, busy}, {639'd0, 1'b1});
    tick();
    check("tmo_fire", {639'd0, err_tmo}, {639'd0, 1'b1});
    check("tmo_busy_clr", {639'd0, busy}, 640'd0);
    tick();
    check("tmo_pulse_end", {639'd0, err_tmo}, 640'd0);
    idle(TMO + 4);
    check("tmo_once", 640'(n_tmo - t0), 640'd1);
    check("tmo_blk_hdr", blk_hdr, saved);
    check("tmo_no_vld", 640'(n_vld - v0), 640'd0);
    send_frame(8'h01, 8'h01);
    check("tmo_next_blk_hdr", blk_hdr, frame_model(8'h01, 8'h01));
    check("tmo_next_cnt", {632'd0, hdr_cnt}, 640'd9);
    tick();

    // A byte landing in the expiry cycle is accepted and suppresses the timeout.
    t0 = n_tmo;
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'h55);
    idle(TMO - 1);
    for (int i = 0; i < 70; i++) send_byte(8'h55);
`ifdef HDR_CHKSUM_EN
    send_byte(8'h00);
`endif
    check("edge_vld", {639'd0, hdr_vld}, {639'd0, 1'b1});
    check("edge_blk_hdr", blk_hdr, frame_model(8'h55, 8'h00));
    check("edge_no_tmo", 640'(n_tmo - t0), 640'd0);
    check("edge_cnt", {632'd0, hdr_cnt}, 640'd10);
    tick();

`ifdef HDR_CHKSUM_EN
    // Checksum 00 is correct for payload 00..4F; 01 must be rejected.
    send_byte(8'hA5);
    for (int i = 0; i < 80; i++) send_byte(8'(i));
    send_byte(8'h00);
    check("chk_ok_vld", {639'd0, hdr_vld}, {639'd0, 1'b1});
    check("chk_ok_cnt", {632'd0, hdr_cnt}, 640'd11);
    tick();
    saved = blk_hdr;
    v0 = n_vld;
    t0 = n_cerr;
    send_byte(8'hA5);
    for (int i = 0; i < 80; i++) send_byte(8'(i + 1));
    send_byte(8'h01);
    check("chk_bad_err", {639'd0, err_chk}, {639'd0, 1'b1});
    check("chk_bad_no_vld", {639'd0, hdr_vld}, 640'd0);
    tick();
    check("chk_bad_once", 640'(n_cerr - t0), 640'd1);
    check("chk_bad_no_pub", 640'(n_vld - v0), 640'd0);
    check("chk_bad_blk_hdr", blk_hdr, saved);
`endif

    // Reset mid-frame discards the partial frame silently.
    v0 = n_vld;
    t0 = n_tmo + n_cerr;
    send_byte(8'hA5);
    for (int i = 0; i < 50; i++) send_byte(8'h99);
    do_reset();
    check("midrst_blk_hdr", blk_hdr, {640{1'b0}});
    check("midrst_cnt", {632'd0, hdr_cnt}, 640'd0);
    check("midrst_busy", {639'd0, busy}, 640'd0);
    idle(TMO + 4);
    check("midrst_no_pulses", 640'((n_vld - v0) + (n_tmo + n_cerr - t0)), 640'd0);
    send_frame(8'h09, 8'h07);
    check("midrst_next_vld", {639'd0, hdr_vld}, {639'd0, 1'b1});
    check("midrst_next_cnt", {632'd0, hdr_cnt}, 640'd1);
    check("midrst_next_blk", blk_hdr, frame_model(8'h09, 8'h07));
    tick();

    // 256 frames wrap hdr_cnt back to zero.
    do_reset();
    v0 = n_vld;
    for (int k = 0; k < 256; k++) begin
      send_frame(8'(k), 8'h3B);
      if (k == 254) check("wrap_cnt_255", {632'd0, hdr_cnt}, 640'd255);
      tick();
    end
    check("wrap_cnt_0", {632'd0, hdr_cnt}, 640'd0);
    check("wrap_blk_hdr", blk_hdr, frame_model(8'hFF, 8'h3B));
    check("wrap_pulses", 640'(n_vld - v0), 640'd256);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
